// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   state_t    - responder FSM states (IDLE / WAIT / RESP)
//   WORD_W     - data word width in bits
//   BE_W       - number of byte enables per word
//   LAT_W      - width of the wait-latency counter (LATENCY range 0..15)
//   word_index - byte address to word index, wrapped modulo depth words
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int LAT_W  = 4;

  // Drops the byte offset and wraps to the array size. depth must be a
  // power of two, so masking with depth-1 is the modulo.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned depth);
    return (addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit word storage with per-byte write enables.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low clear of every word and the read register
//   wr_en   - write the lanes selected by be at addr
//   be      - byte enables, bit i covers wdata[8i+7:8i]
//   addr    - word index
//   wdata   - write data
//   rd_en   - register the word at addr into rdata
//   clr_en  - register zero into rdata (used when no read data is returned)
//   rdata   - registered read data, holds between accesses
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     rd_en,
  input  logic                     clr_en,
  output logic [WORD_W-1:0]        rdata
);

  // Storage is split into one array per byte lane so each lane has a
  // single writer and its own registered read slice.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_reg [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            lane_reg[i] <= '0;
          end
        end else if (wr_en && be[gi]) begin
          lane_reg[addr] <= wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          rd_byte_reg <= '0;
        end else if (rd_en) begin
          rd_byte_reg <= lane_reg[addr];
        end else if (clr_en) begin
          rd_byte_reg <= '0;
        end
      end

      assign rdata[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with a programmable wait latency.
// One transaction is outstanding at a time: accept in IDLE, count LATENCY
// wait cycles, perform the access on the edge into RESP, then hold the
// response until the core takes it.
// Ports:
//   clock, reset            - clock and asynchronous active-low reset
//   req_valid / req_ready   - request handshake (req_ready decoded from state)
//   req_write, req_addr,
//   req_wdata, req_be       - request payload (store flag, byte address,
//                             store data, store byte enables)
//   rsp_valid / rsp_ready   - response handshake
//   rsp_rdata               - load data, 0 for stores and rejected requests
//   rsp_err                 - request rejected by the address check
// Build option: DMEM_RANGE_CHECK_EN enables the address check (misaligned
// or beyond DEPTH words -> error, no write). Without it rsp_err stays 0 and
// addresses wrap modulo DEPTH words.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_t            state_reg, state_next;
  logic [LAT_W-1:0]  cnt_reg, cnt_next;
  logic              write_reg;
  logic [31:0]       addr_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic [BE_W-1:0]   be_reg;
  logic              err_reg;

  logic              accept;
  logic              access;
  logic              acc_write;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic [AW-1:0]     acc_index;

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    access     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            access     = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          access     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge, so the
  // request is taken straight from the ports rather than from the latch.
  always_comb begin
    acc_write = write_reg;
    acc_addr  = addr_reg;
    acc_wdata = wdata_reg;
    acc_be    = be_reg;
    if (state_reg == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_index = AW'(word_index(acc_addr, DEPTH));

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (AW + 2)) != '0);
`else
  assign acc_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= req_write;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        be_reg    <= req_be;
      end
      if (access) begin
        err_reg <= acc_err;
      end
    end
  end

  assign rsp_err = err_reg;

  // Rejected requests neither write nor read; they return zero data.
  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (access && acc_write && !acc_err),
    .be     (acc_be),
    .addr   (acc_index),
    .wdata  (acc_wdata),
    .rd_en  (access && !acc_write && !acc_err),
    .clr_en (access && (acc_write || acc_err)),
    .rdata  (rsp_rdata)
  );

endmodule
